// File: rtl/fetch_sequencer.sv
// Program-counter sequencer: steps, redirects or halts a fetch stream, one
// instruction retired per non-stalled RUN cycle, with a one-cycle bubble after redirects.
module fetch_sequencer #(
    parameter int PC_W       = 10,
    parameter int START_ADDR = 0,
    parameter int CNT_W      = 16
) (
    input  logic             Clk_i,
    input  logic             Reset_i,
    input  logic             Start_i,
    input  logic             Jump_i,
    input  logic             BranchEn_i,
    input  logic             Zero_i,
    input  logic [PC_W-1:0]  Target_i,
    input  logic             Halt_i,
    input  logic             Stall_i,
    output logic [PC_W-1:0]  ProgCtr_o,
    output logic             FetchValid_o,
    output logic             Busy_o,
    output logic             Done_o,
    output logic [CNT_W-1:0] RetCount_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_FLUSH  = 2'd2;
    localparam logic [1:0] S_HALTED = 2'd3;

    localparam logic [PC_W-1:0]  START_PC = PC_W'(START_ADDR);
    localparam logic [PC_W-1:0]  PC_ONE   = PC_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire;
    logic             redirect;

    // Decoder inputs only matter on a retire edge; a stalled RUN cycle is inert.
    assign retire   = (state_q == S_RUN) && !Stall_i;
    assign redirect = Jump_i || (BranchEn_i && Zero_i);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_HALTED: begin
                if (Start_i) begin
                    pc_d    = START_PC;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (retire) begin
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                    if (Halt_i) begin
                        state_d = S_HALTED;
                    end else if (redirect) begin
                        pc_d    = Target_i;
                        state_d = S_FLUSH;
                    end else begin
                        pc_d = pc_q + PC_ONE;
                    end
                end
            end
            S_FLUSH: begin
                state_d = S_RUN;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ProgCtr_o    = pc_q;
    assign RetCount_o   = cnt_q;
    assign FetchValid_o = (state_q == S_RUN);
    assign Busy_o       = (state_q == S_RUN) || (state_q == S_FLUSH);
    assign Done_o       = (state_q == S_HALTED);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a default instance and a narrow one (4-bit PC from 15,
// 3-bit counter) share stimulus and are both checked against an abstract model.
module tb_fetch_sequencer;

    logic       clk;
    logic       rst, start, jump, bren, zero, halt, stall;
    logic [9:0] target;

    logic [9:0]  pc_a;
    logic        fv_a, busy_a, done_a;
    logic [15:0] ret_a;
    logic [3:0]  pc_b;
    logic        fv_b, busy_b, done_b;
    logic [2:0]  ret_b;

    int n_cmp = 0;
    int n_err = 0;

    typedef enum {M_IDLE, M_RUN, M_FLUSH, M_HALT} mst_t;
    mst_t m_st[2];
    int   m_pc[2];
    int   m_ret[2];
    int   pcmod[2] = '{1024, 16};
    int   cmax[2]  = '{65535, 7};
    int   saddr[2] = '{0, 15};

    fetch_sequencer dut_a (
        .Clk_i(clk), .Reset_i(rst), .Start_i(start), .Jump_i(jump),
        .BranchEn_i(bren), .Zero_i(zero), .Target_i(target), .Halt_i(halt),
        .Stall_i(stall), .ProgCtr_o(pc_a), .FetchValid_o(fv_a), .Busy_o(busy_a),
        .Done_o(done_a), .RetCount_o(ret_a)
    );

    fetch_sequencer #(.PC_W(4), .START_ADDR(15), .CNT_W(3)) dut_b (
        .Clk_i(clk), .Reset_i(rst), .Start_i(start), .Jump_i(jump),
        .BranchEn_i(bren), .Zero_i(zero), .Target_i(target[3:0]), .Halt_i(halt),
        .Stall_i(stall), .ProgCtr_o(pc_b), .FetchValid_o(fv_b), .Busy_o(busy_b),
        .Done_o(done_b), .RetCount_o(ret_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k]  = M_IDLE;
            m_pc[k]  = 0;
            m_ret[k] = 0;
        end
    endfunction

    // What one rising edge does to each program, given the inputs now applied.
    function automatic void model_edge();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_st[k] = M_IDLE; m_pc[k] = 0; m_ret[k] = 0;
            end else if (m_st[k] == M_IDLE || m_st[k] == M_HALT) begin
                if (start) begin
                    m_st[k] = M_RUN; m_pc[k] = saddr[k]; m_ret[k] = 0;
                end
            end else if (m_st[k] == M_FLUSH) begin
                m_st[k] = M_RUN;
            end else if (!stall) begin
                m_ret[k] = (m_ret[k] < cmax[k]) ? m_ret[k] + 1 : cmax[k];
                if (halt) m_st[k] = M_HALT;
                else if (jump || (bren && zero)) begin
                    m_pc[k] = int'(target) % pcmod[k];
                    m_st[k] = M_FLUSH;
                end else m_pc[k] = (m_pc[k] + 1) % pcmod[k];
            end
        end
    endfunction

    task automatic check_all();
        chk("A.pc",   32'(pc_a),   32'(m_pc[0]));
        chk("A.fv",   32'(fv_a),   32'(m_st[0] == M_RUN));
        chk("A.busy", 32'(busy_a), 32'(m_st[0] == M_RUN || m_st[0] == M_FLUSH));
        chk("A.done", 32'(done_a), 32'(m_st[0] == M_HALT));
        chk("A.ret",  32'(ret_a),  32'(m_ret[0]));
        chk("B.pc",   32'(pc_b),   32'(m_pc[1]));
        chk("B.fv",   32'(fv_b),   32'(m_st[1] == M_RUN));
        chk("B.busy", 32'(busy_b), 32'(m_st[1] == M_RUN || m_st[1] == M_FLUSH));
        chk("B.done", 32'(done_b), 32'(m_st[1] == M_HALT));
        chk("B.ret",  32'(ret_b),  32'(m_ret[1]));
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic ctl(input logic j, input logic b, input logic z, input logic h,
                       input logic s, input logic [9:0] t);
        jump = j; bren = b; zero = z; halt = h; stall = s; target = t;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        ctl(0, 0, 0, 0, 0, 10'd0);
        #1;
        model_reset();
        chk("rst.pc", 32'(pc_a), 32'd0);
        chk("rst.fv", 32'(fv_a), 32'd0);
        chk("rst.busy", 32'(busy_a), 32'd0);
        chk("rst.done", 32'(done_a), 32'd0);
        chk("rst.ret", 32'(ret_a), 32'd0);
        cycle(); cycle();
        rst = 1'b0;
        cycle(); cycle();
        chk("idle.busy", 32'(busy_a), 32'd0);

        start = 1'b1; cycle(); start = 1'b0;
        chk("start.pcA", 32'(pc_a), 32'd0);
        chk("start.pcB", 32'(pc_b), 32'd15);
        for (int i = 1; i <= 5; i++) begin
            cycle();
            chk("seq.pc", 32'(pc_a), 32'(i));
            chk("seq.fv", 32'(fv_a), 32'd1);
            if (i == 1) chk("wrap.pcB", 32'(pc_b), 32'd0);
        end
        chk("seq.ret", 32'(ret_a), 32'd5);

        ctl(1, 0, 0, 0, 0, 10'd3); cycle();
        ctl(0, 0, 0, 0, 0, 10'd0); cycle();
        chk("pc3", 32'(pc_a), 32'd3);
        ctl(1, 0, 0, 0, 0, 10'd40); cycle();
        chk("jmp.pc", 32'(pc_a), 32'd40);
        chk("jmp.fv", 32'(fv_a), 32'd0);
        chk("jmp.ret", 32'(ret_a), 32'd7);
        ctl(1, 0, 0, 0, 0, 10'd77); cycle();
        chk("flush.pc", 32'(pc_a), 32'd40);
        chk("flush.fv", 32'(fv_a), 32'd1);
        chk("flush.ret", 32'(ret_a), 32'd7);

        ctl(1, 0, 0, 0, 0, 10'd7); cycle();
        ctl(0, 0, 0, 0, 0, 10'd0); cycle();
        ctl(0, 1, 0, 0, 0, 10'd2); cycle();
        chk("bnt.pc", 32'(pc_a), 32'd8);
        ctl(0, 1, 1, 0, 0, 10'd2); cycle();
        chk("bt.fv", 32'(fv_a), 32'd0);
        ctl(0, 0, 0, 0, 0, 10'd0); cycle();
        chk("bt.pc", 32'(pc_a), 32'd2);
        cycle(); cycle();

        for (int i = 0; i < 3; i++) begin
            ctl(1, 0, 0, 0, 1, 10'd100); cycle();
            chk("stall.pc", 32'(pc_a), 32'd4);
            chk("stall.ret", 32'(ret_a), 32'd12);
        end
        ctl(1, 0, 0, 0, 0, 10'd100); cycle();
        chk("unstall.pc", 32'(pc_a), 32'd100);
        chk("unstall.ret", 32'(ret_a), 32'd13);
        ctl(0, 0, 0, 0, 0, 10'd0); cycle();
        ctl(1, 0, 0, 0, 0, 10'd9); cycle();
        ctl(0, 0, 0, 0, 0, 10'd0); cycle();

        ctl(1, 0, 0, 1, 0, 10'd33); cycle();
        chk("halt.pc", 32'(pc_a), 32'd9);
        chk("halt.done", 32'(done_a), 32'd1);
        chk("halt.ret", 32'(ret_a), 32'd15);
        ctl(0, 0, 0, 0, 0, 10'd0); cycle();
        start = 1'b1; cycle();
        chk("restart.pc", 32'(pc_a), 32'd0);
        chk("restart.ret", 32'(ret_a), 32'd0);
        cycle(); cycle();
        chk("runstart.pc", 32'(pc_a), 32'd2);
        chk("runstart.ret", 32'(ret_a), 32'd2);
        start = 1'b0;

        ctl(1, 0, 0, 0, 0, 10'd50); cycle();
        ctl(0, 0, 0, 0, 0, 10'd0);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst.pc", 32'(pc_a), 32'd0);
        chk("arst.busy", 32'(busy_a), 32'd0);
        chk("arst.ret", 32'(ret_a), 32'd0);
        check_all();
        start = 1'b1; cycle();
        start = 1'b0; rst = 1'b0;
        cycle(); cycle();
        chk("postrst.fv", 32'(fv_a), 32'd0);

        for (int n = 0; n < 800; n++) begin
            start  = ($urandom_range(0, 9) == 0);
            stall  = ($urandom_range(0, 3) == 0);
            halt   = ($urandom_range(0, 24) == 0);
            jump   = ($urandom_range(0, 6) == 0);
            bren   = ($urandom_range(0, 3) == 0);
            zero   = $urandom_range(0, 1) == 1;
            target = 10'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                #3;
                rst = 1'b1;
                #1;
                model_reset();
                check_all();
                #1;
                rst = 1'b0;
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
